// File: rtl/peak_period_meter.sv
// Measures the interval between accepted peak events and the amplitude at each one.
// It keeps a 4-sample amplitude average and reports lock and timeout status.
module peak_period_meter #(
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             i_clock,
   input  logic             i_RESET,
   input  logic             i_peak_detected,
   input  logic [31:0]      i_peak,
   output logic [CNT_W-1:0] o_period,
   output logic [31:0]      o_amplitude,
   output logic [31:0]      o_amp_avg,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   typedef enum logic [1:0] {IDLE, BLANK, COUNT} state_t;

   localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, state_d;
   logic             pdet_q;
   logic             rise;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [CNT_W-1:0] period_d;
   logic [31:0]      amplitude_d, amp_avg_d;
   logic             valid_d, locked_d, timeout_d;
   logic [2:0]       lock_cnt, lock_cnt_d;
   logic [31:0]      h0, h1, h2, h0_d, h1_d, h2_d;
   logic [33:0]      sum;

   assign rise = i_peak_detected & ~pdet_q;

   // The oldest history entry drops out of the average, so only three are stored.
   assign sum = {2'b00, h2} + {2'b00, h1} + {2'b00, h0} + {2'b00, i_peak};

   always_comb begin
      // NOTE: every variable gets a default here first, so no path can infer a latch.
      state_d     = state;
      cnt_d       = cnt;
      period_d    = o_period;
      amplitude_d = o_amplitude;
      amp_avg_d   = o_amp_avg;
      valid_d     = 1'b0;
      timeout_d   = o_timeout;
      lock_cnt_d  = lock_cnt;
      h0_d        = h0;
      h1_d        = h1;
      h2_d        = h2;

      unique case (state)
         IDLE: begin
            cnt_d = '0;
            if (rise) begin
               amplitude_d = i_peak;
               timeout_d   = 1'b0;
               state_d     = BLANK;
            end
         end
         BLANK: begin
            cnt_d = cnt + 1'b1;
            if (cnt == BLANK_LAST) state_d = COUNT;
         end
         COUNT: begin
            // An accept on the timeout edge wins over the timeout.
            if (rise) begin
               period_d    = cnt + 1'b1;
               amplitude_d = i_peak;
               h2_d        = h1;
               h1_d        = h0;
               h0_d        = i_peak;
               amp_avg_d   = sum[33:2];
               valid_d     = 1'b1;
               lock_cnt_d  = (lock_cnt == 3'd4) ? 3'd4 : lock_cnt + 3'd1;
               cnt_d       = '0;
               timeout_d   = 1'b0;
               state_d     = BLANK;
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_d  = 1'b1;
               lock_cnt_d = 3'd0;
               h0_d       = '0;
               h1_d       = '0;
               h2_d       = '0;
               cnt_d      = '0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      locked_d = (lock_cnt_d == 3'd4);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         state       <= IDLE;
         pdet_q      <= 1'b0;
         cnt         <= '0;
         o_period    <= '0;
         o_amplitude <= '0;
         o_amp_avg   <= '0;
         o_valid     <= 1'b0;
         o_locked    <= 1'b0;
         o_timeout   <= 1'b0;
         lock_cnt    <= 3'd0;
         h0          <= '0;
         h1          <= '0;
         h2          <= '0;
      end else begin
         state       <= state_d;
         pdet_q      <= i_peak_detected;
         cnt         <= cnt_d;
         o_period    <= period_d;
         o_amplitude <= amplitude_d;
         o_amp_avg   <= amp_avg_d;
         o_valid     <= valid_d;
         o_locked    <= locked_d;
         o_timeout   <= timeout_d;
         lock_cnt    <= lock_cnt_d;
         h0          <= h0_d;
         h1          <= h1_d;
         h2          <= h2_d;
      end
   end

endmodule

// File: tb/tb_peak_period_meter.sv
// Scoreboard bench for peak_period_meter: stimulus pushes expected strobes,
// a negedge monitor pops and compares whenever o_valid is seen.
module tb_peak_period_meter;

   localparam int unsigned CNT_W = 32;

   logic             i_clock;
   logic             i_RESET;
   logic             i_peak_detected;
   logic [31:0]      i_peak;
   logic [CNT_W-1:0] o_period;
   logic [31:0]      o_amplitude;
   logic [31:0]      o_amp_avg;
   logic             o_valid;
   logic             o_locked;
   logic             o_timeout;

   typedef struct {
      logic [31:0] period;
      logic [31:0] amp;
      logic [31:0] avg;
      logic        locked;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   peak_period_meter #(
      .BLANK_CYCLES  (16),
      .TIMEOUT_CYCLES(1000),
      .CNT_W         (CNT_W)
   ) dut (
      .i_clock        (i_clock),
      .i_RESET        (i_RESET),
      .i_peak_detected(i_peak_detected),
      .i_peak         (i_peak),
      .o_period       (o_period),
      .o_amplitude    (o_amplitude),
      .o_amp_avg      (o_amp_avg),
      .o_valid        (o_valid),
      .o_locked       (o_locked),
      .o_timeout      (o_timeout)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_valid(input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] v, input logic l);
      exp_t e;
      e.period = p;
      e.amp    = a;
      e.avg    = v;
      e.locked = l;
      q.push_back(e);
   endtask

   // Called from posedge+1; the rise is sampled n edges after the previous sample edge.
   task automatic peak_at(input int n, input logic [31:0] amp, input int hold = 1);
      repeat (n - 1) begin
         @(posedge i_clock);
         #1;
      end
      i_peak          = amp;
      i_peak_detected = 1'b1;
      repeat (hold) begin
         @(posedge i_clock);
         #1;
      end
      i_peak_detected = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_period"}, 64'(o_period), 64'd0);
      check({tag, "_amplitude"}, 64'(o_amplitude), 64'd0);
      check({tag, "_avg"}, 64'(o_amp_avg), 64'd0);
      check({tag, "_valid"}, 64'(o_valid), 64'd0);
      check({tag, "_locked"}, 64'(o_locked), 64'd0);
      check({tag, "_timeout"}, 64'(o_timeout), 64'd0);
   endtask

   // Monitor: every o_valid strobe must match the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clock);
         if (o_valid) begin
            if (q.size() == 0) begin
               check("unexpected_valid", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("sb_period", 64'(o_period), 64'(e.period));
               check("sb_amplitude", 64'(o_amplitude), 64'(e.amp));
               check("sb_avg", 64'(o_amp_avg), 64'(e.avg));
               check("sb_locked", 64'(o_locked), 64'(e.locked));
               check("sb_timeout", 64'(o_timeout), 64'd0);
            end
         end
      end
   end

   initial begin
      i_RESET         = 1'b0;
      i_peak_detected = 1'b0;
      i_peak          = '0;
      repeat (3) @(posedge i_clock);
      #3;
      check_zero("reset");
      i_RESET = 1'b1;

      // Idle for longer than the timeout: nothing may change.
      repeat (1100) @(posedge i_clock);
      #1;
      check_zero("idle");

      // Regular train, first peak from IDLE gives no strobe.
      peak_at(1, 32'd1000);
      check("first_amplitude", 64'(o_amplitude), 64'd1000);
      check("first_period", 64'(o_period), 64'd0);
      expect_valid(100, 1200, 300, 1'b0);
      peak_at(100, 32'd1200);
      expect_valid(100, 1400, 650, 1'b0);
      peak_at(100, 32'd1400);
      expect_valid(100, 1600, 1050, 1'b0);
      peak_at(100, 32'd1600);
      expect_valid(100, 1800, 1500, 1'b1);
      peak_at(100, 32'd1800);

      // Chatter inside the blanking window: rises at 3 and 10, level held 12..16.
      peak_at(3, 32'd5555);
      peak_at(7, 32'd6666);
      peak_at(2, 32'd7777, 5);
      expect_valid(100, 2000, 1700, 1'b1);
      peak_at(84, 32'd2000);

      // Blanking boundary: rise at 16 ignored, later a rise at 17 is accepted.
      peak_at(16, 32'd3333);
      expect_valid(100, 2200, 1900, 1'b1);
      peak_at(84, 32'd2200);
      expect_valid(17, 2400, 2100, 1'b1);
      peak_at(17, 32'd2400);

      // Rise on the timeout edge is accepted.
      expect_valid(1000, 2600, 2300, 1'b1);
      peak_at(1000, 32'd2600);
      check("maxper_timeout", 64'(o_timeout), 64'd0);

      // Timeout after 1000 cycles with no rise.
      repeat (999) @(posedge i_clock);
      #1;
      check("pre_timeout", 64'(o_timeout), 64'd0);
      @(posedge i_clock);
      #1;
      check("timeout", 64'(o_timeout), 64'd1);
      check("timeout_locked", 64'(o_locked), 64'd0);
      check("timeout_period", 64'(o_period), 64'd1000);
      check("timeout_amplitude", 64'(o_amplitude), 64'd2600);
      check("timeout_avg", 64'(o_amp_avg), 64'd2300);
      peak_at(5, 32'd4000);
      check("rearm_timeout", 64'(o_timeout), 64'd0);
      check("rearm_amplitude", 64'(o_amplitude), 64'd4000);
      expect_valid(50, 4400, 1100, 1'b0);
      peak_at(50, 32'd4400);

      // Asynchronous reset in the middle of COUNT.
      repeat (30) @(posedge i_clock);
      #3;
      i_RESET = 1'b0;
      #1;
      check_zero("async_reset");
      #10;
      i_RESET = 1'b1;
      @(posedge i_clock);
      #1;
      peak_at(1, 32'd5000);
      check("post_reset_amplitude", 64'(o_amplitude), 64'd5000);
      check("post_reset_period", 64'(o_period), 64'd0);
      expect_valid(40, 6000, 1500, 1'b0);
      peak_at(40, 32'd6000);

      repeat (5) @(posedge i_clock);
      #1;
      check("sb_drain", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
